// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder; the sub signal exists only when
// SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
    // Handshake: a request is accepted on a rising edge where start=1 and busy=0.
    // a/b/sub are captured on that edge only. busy stays high until the edge after
    // the one-cycle done pulse. start while busy=1 is dropped, never queued.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, carry);
    modport slave  (input start, a, b, sub, output busy, done, sum, carry);
`else
    modport master (output start, a, b, input busy, done, sum, carry);
    modport slave  (input start, a, b, output busy, done, sum, carry);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-add cell (two half adders + carry flop) per clock.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b via inverted b and carry-in 1).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_if.slave      bus,
    output logic [1:0]         state_dbg
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nx;
    logic [WIDTH-1:0] b_load;
    logic             c, c_init;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             ha1_s, ha1_c, ha2_s, ha2_c, c_nx;
    logic             busy_q, done_q, carry_q;
    logic [WIDTH-1:0] sum_q;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = bus.sub ? ~bus.b : bus.b;
    assign c_init = bus.sub;
`else
    assign b_load = bus.b;
    assign c_init = 1'b0;
`endif

    // Full-add cell: first half adder on the operand bits, second adds the carry.
    always_comb begin
        ha1_s = a_sh[0] ^ b_sh[0];
        ha1_c = a_sh[0] & b_sh[0];
        ha2_s = ha1_s ^ c;
        ha2_c = ha1_s & c;
        c_nx  = ha1_c | ha2_c;
        r_nx  = (r_sh >> 1) | (WIDTH'(ha2_s) << (WIDTH - 1));
    end

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh <= bus.a;
                        b_sh <= b_load;
                        c    <= c_init;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_nx;
                    c    <= c_nx;
                    cnt  <= cnt + CW'(1);
                    // Final bit goes straight into sum so it is valid with done.
                    if (last) begin
                        sum_q   <= r_nx;
                        carry_q <= c_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
    assign state_dbg = state;
endmodule
